// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with boot-time load port and a
// one-entry fetch response; `IMEM_PARITY_EN adds per-word parity.
module instr_mem_sync #(
  parameter int               DEPTH     = 256,
  parameter int               WIDTH     = 32,
  parameter int               ADDR_W    = 32,
  parameter bit               BOOT_LOAD = 1'b1,
  parameter logic [WIDTH-1:0] NOP_WORD  = WIDTH'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     load_done,
`ifdef IMEM_PARITY_EN
  input  logic                     load_perr_inject,
  output logic                     resp_perr,
`endif
  output logic                     booted
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr;
  logic              accept;
  logic              misal;
  logic              oor;
  logic              rd_perr;
  logic [AW-1:0]     idx;
  logic [ADDR_W-1:0] hi;

  assign fetch_ready = booted & (~resp_valid | resp_ready);
  assign accept      = fetch_valid & fetch_ready;
  assign wr          = (state == BOOT) & load_en;

  // Upper bits past the array must be zero: no aliasing to low words.
  assign idx   = fetch_addr[AW+1:2];
  assign hi    = fetch_addr >> (AW + 2);
  assign misal = |fetch_addr[1:0];
  assign oor   = |hi;

  always_ff @(posedge clk) begin
    if (wr) mem[load_addr] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr) par[load_addr] <= (^load_data) ^ load_perr_inject;
  end

  assign rd_perr = (^mem[idx]) != par[idx];
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BOOT_LOAD ? BOOT : RUN;
      booted <= ~BOOT_LOAD;
    end else if (state == BOOT && load_done) begin
      state  <= RUN;
      booted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
      resp_perr  <= 1'b0;
`endif
    end else if (accept) begin
      resp_valid <= 1'b1;
      if (misal | oor | rd_perr) begin
        resp_data  <= NOP_WORD;
        resp_fault <= 1'b1;
      end else begin
        resp_data  <= mem[idx];
        resp_fault <= 1'b0;
      end
`ifdef IMEM_PARITY_EN
      resp_perr  <= ~misal & ~oor & rd_perr;
`endif
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: boot load, fetch handshake,
// stalls, address faults, reset retention and optional parity faults.
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        booted;
`ifdef IMEM_PARITY_EN
  logic        load_perr_inject;
  logic        resp_perr;
`endif

  instr_mem_sync dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_fault  (resp_fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
`ifdef IMEM_PARITY_EN
    .load_perr_inject (load_perr_inject),
    .resp_perr   (resp_perr),
`endif
    .booted      (booted)
  );

  typedef struct packed {
    logic        f;
    logic        p;
    logic [31:0] d;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        q[$];
  logic [31:0] mdl  [256];
  logic        mbad [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.p = 1'b0;
    if (a[1:0] != 2'b00 || a >= 32'd1024) begin
      e.f = 1'b1;
      e.d = NOP;
    end else if (mbad[a[9:2]]) begin
      e.f = 1'b1;
      e.p = 1'b1;
      e.d = NOP;
    end else begin
      e.f = 1'b0;
      e.d = mdl[a[9:2]];
    end
    return e;
  endfunction

  // Handshakes resolve at the next rising edge; judge them mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      chk("valid", 64'(resp_valid), 64'(q.size() != 0));
      if (resp_valid && resp_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("data", 64'(resp_data), 64'(e.d));
        chk("fault", 64'(resp_fault), 64'(e.f));
`ifdef IMEM_PARITY_EN
        chk("perr", 64'(resp_perr), 64'(e.p));
`endif
      end
      if (fetch_valid && fetch_ready) q.push_back(model(fetch_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d,
                      input logic inj, input logic upd);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
`ifdef IMEM_PARITY_EN
    load_perr_inject = inj;
`endif
    step();
    load_en = 1'b0;
`ifdef IMEM_PARITY_EN
    load_perr_inject = 1'b0;
    if (upd) mbad[a] = inj;
`endif
    if (upd) mdl[a] = d;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    step();
    fetch_valid = 1'b0;
  endtask

  logic [31:0] picks [6];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl[i]  = 32'h0;
      mbad[i] = 1'b0;
    end
    picks[0] = 32'h0;
    picks[1] = 32'h4;
    picks[2] = 32'h8;
    picks[3] = 32'hc;
    picks[4] = 32'h6;
    picks[5] = 32'h400;
    rst = 1'b1;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    resp_ready  = 1'b1;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    load_done   = 1'b0;
`ifdef IMEM_PARITY_EN
    load_perr_inject = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    chk("rst_booted", 64'(booted), 64'd0);
    chk("rst_fready", 64'(fetch_ready), 64'd0);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_data), 64'd0);
    chk("rst_rfault", 64'(resp_fault), 64'd0);

    load(8'd0, 32'h00500113, 1'b0, 1'b1);
    load(8'd1, 32'h00c00193, 1'b0, 1'b1);
    load(8'd2, 32'hff718393, 1'b1, 1'b1);
    load(8'd3, 32'h00208233, 1'b0, 1'b1);
    chk("boot_booted", 64'(booted), 64'd0);
    chk("boot_fready", 64'(fetch_ready), 64'd0);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("run_booted", 64'(booted), 64'd1);
    chk("run_fready", 64'(fetch_ready), 64'd1);

    // Back-to-back fetches at full rate.
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    step();
    chk("b2b_fready", 64'(fetch_ready), 64'd1);
    fetch_addr = 32'h4;
    step();
    chk("b2b_rdata1", 64'(resp_data), 64'h00c00193);
    fetch_valid = 1'b0;
    step();

    // Consumer stall holds the response and blocks new accepts.
    resp_ready = 1'b0;
    fetch(32'h4);
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_data", 64'(resp_data), 64'h00c00193);
      chk("stall_fready", 64'(fetch_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("unstall_fready", 64'(fetch_ready), 64'd1);
    step();
    fetch_valid = 1'b0;
    chk("unstall_data", 64'(resp_data), 64'h00500113);
    step();

    // Misaligned and out-of-range fetches.
    fetch(32'h6);
    chk("misal_fault", 64'(resp_fault), 64'd1);
    fetch(32'h400);
    chk("oor_data", 64'(resp_data), 64'(NOP));
    fetch(32'hfffffffc);
    fetch(32'h8);
`ifdef IMEM_PARITY_EN
    chk("par_fault", 64'(resp_fault), 64'd1);
    chk("par_perr", 64'(resp_perr), 64'd1);
`endif
    fetch(32'h0);
`ifdef IMEM_PARITY_EN
    chk("par_ok_perr", 64'(resp_perr), 64'd0);
`endif
    step();

    // Reset while a response is stalled: memory survives.
    resp_ready = 1'b0;
    fetch(32'h4);
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_booted", 64'(booted), 64'd0);
    resp_ready = 1'b1;
    load_done  = 1'b1;
    step();
    load_done = 1'b0;
    fetch(32'h0);
    chk("retain_data", 64'(resp_data), 64'h00500113);
    step();

    load(8'd0, 32'hdeadbeef, 1'b0, 1'b0);
    fetch(32'h0);
    chk("ro_data", 64'(resp_data), 64'h00500113);
    step();

    for (int i = 0; i < 80; i++) begin
      fetch_valid = 1'($urandom_range(0, 1));
      resp_ready  = ($urandom_range(0, 3) != 0);
      fetch_addr  = picks[$urandom_range(0, 5)];
      step();
    end

    fetch_valid = 1'b0;
    resp_ready  = 1'b1;
    repeat (3) step();
    chk("drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
